// File: rtl/hex_stream_tx_pkg.sv
// hex_stream_tx_pkg: ASCII constants and FSM state encodings for hex_stream_tx.
// HEX_STREAM_TX_CRLF_EN adds the CR state and a 0x0D 0x0A line terminator.
package hex_stream_tx_pkg;
   localparam logic [7:0] ASCII_CR   = 8'h0D;
   localparam logic [7:0] ASCII_LF   = 8'h0A;
   localparam logic [7:0] ASCII_0    = 8'h30;
   localparam logic [7:0] ASCII_A_UC = 8'h41;
   localparam logic [7:0] ASCII_A_LC = 8'h61;
`ifdef HEX_STREAM_TX_CRLF_EN
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HEX = 2'd1, ST_LF = 2'd2, ST_CR = 2'd3} state_e;
   localparam state_e ST_AFTER_HEX = ST_CR;
`else
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HEX = 2'd1, ST_LF = 2'd2} state_e;
   localparam state_e ST_AFTER_HEX = ST_LF;
`endif
endpackage

// File: rtl/hex_stream_tx_nibble.sv
// hex_nibble_to_ascii: one 4-bit nibble to its ASCII hex character.
module hex_nibble_to_ascii
   import hex_stream_tx_pkg::*;
#(
   parameter bit UPPERCASE = 1'b1
) (
   input  logic [3:0] nibble_i,
   output logic [7:0] char_o
);
   logic [7:0] nib;
   assign nib    = {4'h0, nibble_i};
   assign char_o = (nibble_i < 4'd10) ? ASCII_0 + nib
                 : (UPPERCASE ? ASCII_A_UC : ASCII_A_LC) + nib - 8'd10;
endmodule

// File: rtl/hex_stream_tx.sv
// hex_stream_tx: prints one word per line as MSB-first ASCII hex over a valid/ready byte stream.
// HEX_STREAM_TX_CRLF_EN selects a CR LF terminator instead of LF alone.
module hex_stream_tx
   import hex_stream_tx_pkg::*;
#(
   parameter int WORD_BITS = 32,
   parameter bit UPPERCASE = 1'b1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [WORD_BITS-1:0] word_i,
   input  logic                 word_valid_i,
   output logic                 word_ready_o,
   output logic [7:0]           data_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic                 busy_o
);
   localparam int NIBBLES = WORD_BITS / 4;
   localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   state_e               state_q, state_d;
   logic [WORD_BITS-1:0] shift_q, shift_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [7:0]           hex_char;

   hex_nibble_to_ascii #(.UPPERCASE(UPPERCASE)) u_nib (
      .nibble_i(shift_q[WORD_BITS-1 -: 4]),
      .char_o  (hex_char)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: if (word_valid_i & word_ready_o) begin
            shift_d = word_i;
            cnt_d   = CW'(NIBBLES - 1);
            state_d = ST_HEX;
         end
         ST_HEX: if (ready_i) begin
            shift_d = shift_q << 4;
            cnt_d   = cnt_q - CW'(1);
            state_d = (cnt_q == '0) ? ST_AFTER_HEX : ST_HEX;
         end
`ifdef HEX_STREAM_TX_CRLF_EN
         ST_CR: state_d = ready_i ? ST_LF : ST_CR;
`endif
         ST_LF: state_d = ready_i ? ST_IDLE : ST_LF;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs decode registered state only, so valid_o never sees ready_i.
   always_comb begin
      data_o = (state_q == ST_HEX) ? hex_char : (state_q == ST_LF) ? ASCII_LF : 8'h00;
`ifdef HEX_STREAM_TX_CRLF_EN
      data_o = (state_q == ST_CR) ? ASCII_CR : data_o;
`endif
   end

   assign valid_o      = state_q != ST_IDLE;
   assign busy_o       = state_q != ST_IDLE;
   assign word_ready_o = (state_q == ST_IDLE) & ~rst_i;
endmodule

// File: tb/tb_hex_stream_tx.sv
// tb_hex_stream_tx: three hex_stream_tx instances (32b upper, 32b lower, 8b upper) against a byte-queue model.
module tb_hex_stream_tx;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rdy = 1'b0;
   logic [63:0] wd[3];
   logic       wv[3];
   logic       wr[3];
   logic       vo[3];
   logic       bz[3];
   logic [7:0] dat[3];

   int n_chk = 0;
   int n_fail = 0;

`ifdef HEX_STREAM_TX_CRLF_EN
   localparam int TL = 2;
`else
   localparam int TL = 1;
`endif

   always #5 clk = ~clk;

   hex_stream_tx #(.WORD_BITS(32), .UPPERCASE(1'b1)) dut0 (
      .clk_i(clk), .rst_i(rst), .word_i(wd[0][31:0]), .word_valid_i(wv[0]), .word_ready_o(wr[0]),
      .data_o(dat[0]), .valid_o(vo[0]), .ready_i(rdy), .busy_o(bz[0]));
   hex_stream_tx #(.WORD_BITS(32), .UPPERCASE(1'b0)) dut1 (
      .clk_i(clk), .rst_i(rst), .word_i(wd[1][31:0]), .word_valid_i(wv[1]), .word_ready_o(wr[1]),
      .data_o(dat[1]), .valid_o(vo[1]), .ready_i(rdy), .busy_o(bz[1]));
   hex_stream_tx #(.WORD_BITS(8), .UPPERCASE(1'b1)) dut2 (
      .clk_i(clk), .rst_i(rst), .word_i(wd[2][7:0]), .word_valid_i(wv[2]), .word_ready_o(wr[2]),
      .data_o(dat[2]), .valid_o(vo[2]), .ready_i(rdy), .busy_o(bz[2]));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: each accepted word becomes a queue of expected bytes, one popped per handshake.
   logic [7:0] exq[3][$];
   int   nb[3]  = '{32, 32, 8};
   bit   ucs[3] = '{1'b1, 1'b0, 1'b1};
   logic pv[3], prdy, prst;
   logic [7:0] pd[3];

   initial begin
      prdy = 1'b0;
      prst = 1'b1;
      for (int i = 0; i < 3; i++) begin pv[i] = 1'b0; pd[i] = 8'h00; end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         automatic bit ev = exq[i].size() > 0;
         chk($sformatf("valid%0d", i), vo[i], ev);
         chk($sformatf("busy%0d", i), bz[i], ev);
         chk($sformatf("wready%0d", i), wr[i], !ev && !rst);
         if (ev) chk($sformatf("data%0d", i), dat[i], exq[i][0]);
         if (pv[i] && !prdy && !prst) begin
            chk($sformatf("hold_valid%0d", i), vo[i], 1'b1);
            chk($sformatf("hold_data%0d", i), dat[i], pd[i]);
         end
         pv[i] = vo[i];
         pd[i] = dat[i];
         if (rst) exq[i].delete();
         else if (ev && rdy) void'(exq[i].pop_front());
         else if (!ev && wv[i]) begin
            for (int n = nb[i] / 4 - 1; n >= 0; n--) begin
               automatic logic [7:0] nib = {4'h0, wd[i][n*4 +: 4]};
               exq[i].push_back(nib < 8'd10 ? 8'h30 + nib : (ucs[i] ? 8'h37 : 8'h57) + nib);
            end
            if (TL == 2) exq[i].push_back(8'h0D);
            exq[i].push_back(8'h0A);
         end
      end
      prdy = rdy;
      prst = rst;
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [7:0] term_at(input int k);
      return (k == 8 && TL == 2) ? 8'h0D : 8'h0A;
   endfunction

   logic [7:0] e0[8] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44};
   logic [7:0] e1[8] = '{8'h64, 8'h65, 8'h61, 8'h64, 8'h62, 8'h65, 8'h65, 8'h66};
   logic [7:0] e3[8] = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h31};
   logic       v2[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   logic [7:0] d2[9] = '{8'h30, 8'h46, 8'h0A, 8'h00, 8'h41, 8'h30, 8'h0A, 8'h00, 8'h00};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      automatic bit done = 1'b0;
      automatic logic p[3];
      for (int i = 0; i < 3; i++) begin wv[i] = 1'b0; wd[i] = '0; end
      repeat (3) cyc();
      @(negedge clk);
      chk("rst_valid", vo[0], 1'b0);
      chk("rst_data", dat[0], 8'h00);
      chk("rst_busy", bz[0], 1'b0);
      chk("rst_wready", wr[0], 1'b0);
      cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_wready", wr[0], 1'b1);
      chk("post_rst_data", dat[0], 8'h00);
      // Full-speed lines on all three, plus back-to-back 8-bit words.
      cyc();
      rdy = 1'b1;
      wd[0] = 64'h1234ABCD; wd[1] = 64'hDEADBEEF; wd[2] = 64'h0F;
      for (int i = 0; i < 3; i++) wv[i] = 1'b1;
      cyc();
      wv[0] = 1'b0; wv[1] = 1'b0; wd[2] = 64'hA0;
      for (int k = 0; k < 8 + TL; k++) begin
         @(negedge clk);
         chk($sformatf("t1_d0_%0d", k), dat[0], k < 8 ? e0[k] : term_at(k));
         chk($sformatf("t1_d1_%0d", k), dat[1], k < 8 ? e1[k] : term_at(k));
         chk($sformatf("t1_v0_%0d", k), vo[0], 1'b1);
`ifndef HEX_STREAM_TX_CRLF_EN
         chk($sformatf("t1_v2_%0d", k), vo[2], v2[k]);
         if (v2[k]) chk($sformatf("t1_d2_%0d", k), dat[2], d2[k]);
`endif
         if (k == 5) wv[2] = 1'b0;
      end
      @(negedge clk);
      chk("t1_wready_after_lf", wr[0], 1'b1);
      chk("t1_valid_after_lf", vo[0], 1'b0);
      // Pseudo-random back-pressure; model checks order and hold.
      cyc();
      wd[0] = 64'h89ABCDEF; wd[1] = 64'h01234567; wd[2] = 64'h5C;
      for (int i = 0; i < 3; i++) wv[i] = 1'b1;
      for (int c = 0; c < 400 && !done; c++) begin
         for (int i = 0; i < 3; i++) p[i] = wv[i] & wr[i];
         rdy = 1'($urandom_range(0, 1));
         cyc();
         for (int i = 0; i < 3; i++) if (p[i]) wv[i] = 1'b0;
         done = !wv[0] && !wv[1] && !wv[2] &&
                exq[0].size() == 0 && exq[1].size() == 0 && exq[2].size() == 0;
      end
      chk("stall_done", done, 1'b1);
      // Reset in the middle of a line.
      rdy = 1'b1;
      wd[0] = 64'hCAFEF00D; wv[0] = 1'b1;
      cyc();
      wv[0] = 1'b0;
      repeat (3) cyc();
      rst = 1'b1;
      @(negedge clk);
      chk("mid_valid", vo[0], 1'b1);
      chk("mid_data", dat[0], 8'h45);
      cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_drop_valid", vo[0], 1'b0);
      chk("rst_drop_data", dat[0], 8'h00);
      cyc();
      wd[0] = 64'h1; wv[0] = 1'b1;
      cyc();
      wv[0] = 1'b0;
      for (int k = 0; k < 8 + TL; k++) begin
         @(negedge clk);
         chk($sformatf("t3_d0_%0d", k), dat[0], k < 8 ? e3[k] : term_at(k));
      end
      @(negedge clk);
      chk("t3_idle", vo[0], 1'b0);
`ifdef HEX_STREAM_TX_CRLF_EN
      cyc();
      wd[0] = 64'h0; wv[0] = 1'b1;
      cyc();
      wv[0] = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk($sformatf("crlf_d0_%0d", k), dat[0], k < 8 ? 8'h30 : (k == 8 ? 8'h0D : 8'h0A));
      end
`endif
      repeat (3) cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
